main_ctrl_fsm: RTL and testbench
================================

Name: main_ctrl_fsm

Overview:
- Multi-cycle main control unit of the 16-bit CPU; the producer of the ALUOp code that ALUControl consumes.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives datapath enables, mux selects and the 2-bit ALUOp; handshakes with the memory port through mem_ready.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for mem_ready before bus error; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  4  IR[15:12], valid from the DECODE state.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed the current read/write this cycle.
- alu_op  out  2  00 add, 01 sub, 10 use Funct, 11 use opcode (ALUControl encoding).
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = register B, 01 = const 1, 10 = sign-extended immediate.
- pc_write  out  1  PC load enable.
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- ir_write  out  1  IR load enable.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  1 = rd field (R-type), 0 = rt field.
- mem_to_reg  out  1  1 = writeback from MDR.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- bus_err  out  1  sticky; set on memory timeout.
- halted  out  1  sticky; high in HALT.
- state_o  out  4  current state code, for debug.

Behaviour:
- Opcodes:
  - 0000 R-type
  - 0001 ADDI, 0010 ANDI, 0011 ORI
  - 0100 LW, 0101 SW
  - 0110 BEQ, 0111 BNE
  - 1000 JMP
  - 1111 HALT
  - all others illegal.
- Outputs are decoded from the state register (Moore). The only exception is pc_write in BRANCH, which also depends on zero.
- Any output not listed for a state is 0.
- rst high: the next state is RST_S (code 0). In RST_S all outputs are 0, including bus_err and halted, and the wait counter clears. RST_S leads to FETCH unconditionally.
- FETCH:
  - Drives mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1; the FSM then moves to DECODE.
  - Otherwise it stays in FETCH.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=10, alu_op=00 to precompute the branch target.
  - Latches opcode into op_q.
  - Next state by opcode:
    - R/ADDI/ANDI/ORI go to EXEC.
    - LW/SW go to MEMADR.
    - BEQ/BNE go to BRANCH.
    - JMP goes to JUMP.
    - HALT goes to HALT.
    - Illegal: pulse illegal_op and return to FETCH, so the instruction acts as a NOP.
- EXEC:
  - alu_src_a=1.
  - R-type: alu_src_b=00, alu_op=10.
  - I-type: alu_src_b=10, alu_op=11.
  - Next state is ALUWB.
- ALUWB: reg_write=1, mem_to_reg=0, reg_dst=1 only for R-type; then FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; then MEMRD for LW, MEMWR for SW.
- MEMRD: mem_read=1 until mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
- MEMWR: mem_write=1 until mem_ready, then FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_write = zero for BEQ, ~zero for BNE.
  - Next state is FETCH.
- JUMP: pc_write=1, pc_src=10; then FETCH.
- HALT: halted=1, all strobes 0; held until rst.
- Wait counter:
  - Increments each cycle in FETCH/MEMRD/MEMWR while mem_ready=0.
  - Clears on any state change.
  - When it equals TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0), the FSM goes to HALT and sets bus_err. mem_ready in that same cycle wins over the timeout.
- rst takes priority over every transition, including a pending mem_ready.
- Latency in cycles:
  - R/I-type: 4.
  - LW: 5.
  - SW: 4.
  - BEQ/BNE/JMP: 3.
  - Each figure assumes mem_ready arrives on the first request cycle; every wait cycle adds 1.

Optional Feature:
- CTRL_PERF_EN defined adds two outputs:
  - retired_cnt [15:0]: increments on each transition into FETCH from ALUWB, MEMWB, MEMWR, BRANCH or JUMP. It wraps at 0xFFFF→0 and is cleared by rst.
  - stall_cnt [15:0]: counts wait cycles; it saturates at 0xFFFF and is cleared by rst.
- CTRL_PERF_EN undefined: neither port nor counter exists.

Decomposition:
- Shared package cpu16_pkg holds:
  - opcode localparams;
  - ALUOp codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10, ALUOP_IMM=11), shared with ALUControl;
  - alu_src_b/pc_src encodings;
  - the state codes.
- One sub-module: ctrl_wait_timer, holding the wait counter and timeout compare.

Test Plan:
- rst=1 for 2 cycles, then 0 → outputs all 0 in RST_S; FETCH next with mem_read=1, alu_src_b=01, alu_op=00.
- opcode=0000, mem_ready=1 → states FETCH, DECODE, EXEC (alu_op=10, alu_src_b=00), ALUWB (reg_write=1, reg_dst=1); 4 cycles total.
- opcode=0100, mem_ready low for 3 cycles in MEMRD → mem_read held 4 cycles; MEMWB asserts reg_write=1, mem_to_reg=1.
- opcode=0110 with zero=1, then zero=0 → BRANCH alu_op=01; pc_write=1 then 0; opcode 0111 gives the inverse.
- opcode=1010 → illegal_op pulse of 1 cycle, return to FETCH, no reg_write or mem_write.
- TIMEOUT_CYCLES=4, mem_ready=0 in FETCH → after 4 wait cycles halted=1, bus_err=1; rst clears both.

Source files
------------

// File: rtl/cpu16_pkg.sv
// ---------------------------------------------------------------------------
// cpu16_pkg
// Shared definitions for the 16-bit multi-cycle CPU control path.
//   - opcode values (IR[15:12])
//   - ALUOp codes, also consumed by ALUControl
//   - alu_src_b / pc_src mux encodings
//   - main control FSM state codes
//   - ctrl_t bundle of Moore outputs and the state -> outputs decode
// ---------------------------------------------------------------------------
package cpu16_pkg;

    // Opcodes
    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_ANDI  = 4'h2;
    localparam logic [3:0] OP_ORI   = 4'h3;
    localparam logic [3:0] OP_LW    = 4'h4;
    localparam logic [3:0] OP_SW    = 4'h5;
    localparam logic [3:0] OP_BEQ   = 4'h6;
    localparam logic [3:0] OP_BNE   = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // ALUOp codes (ALUControl encoding)
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // FSM state codes (visible on state_o)
    typedef enum logic [3:0] {
        RST_S    = 4'd0,
        FETCH_S  = 4'd1,
        DECODE_S = 4'd2,
        EXEC_S   = 4'd3,
        ALUWB_S  = 4'd4,
        MEMADR_S = 4'd5,
        MEMRD_S  = 4'd6,
        MEMWB_S  = 4'd7,
        MEMWR_S  = 4'd8,
        BRANCH_S = 4'd9,
        JUMP_S   = 4'd10,
        HALT_S   = 4'd11
    } state_t;

    // Outputs that depend only on the state (and the latched opcode)
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       halted;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_JMP) || (op == OP_HALT);
    endfunction

    // Moore decode: every output not named for a state stays 0.
    function automatic ctrl_t moore_ctrl(input state_t st, input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            FETCH_S: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_ONE;
                c.alu_op    = ALUOP_ADD;
                c.pc_src    = PCSRC_ALU;
            end
            DECODE_S: begin
                // Branch target precomputed as PC + imm
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            EXEC_S: begin
                c.alu_src_a = 1'b1;
                if (op == OP_RTYPE) begin
                    c.alu_src_b = SRCB_REGB;
                    c.alu_op    = ALUOP_FUNCT;
                end else begin
                    c.alu_src_b = SRCB_IMM;
                    c.alu_op    = ALUOP_IMM;
                end
            end
            ALUWB_S: begin
                c.reg_write = 1'b1;
                c.reg_dst   = (op == OP_RTYPE);
            end
            MEMADR_S: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            MEMRD_S: c.mem_read = 1'b1;
            MEMWB_S: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWR_S: c.mem_write = 1'b1;
            BRANCH_S: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REGB;
                c.alu_op    = ALUOP_SUB;
                c.pc_src    = PCSRC_ALUOUT;
            end
            JUMP_S: begin
                c.pc_write = 1'b1;
                c.pc_src   = PCSRC_JUMP;
            end
            HALT_S: c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// ---------------------------------------------------------------------------
// ctrl_wait_timer
// Counts cycles spent waiting on mem_ready and flags a memory timeout.
//   clk, rst      : clock, synchronous active-high reset
//   waiting       : FSM is in a state that waits on mem_ready
//   mem_ready     : memory completed the request this cycle
//   state_change  : FSM leaves its current state at the next edge
//   timeout       : counter reached TIMEOUT_CYCLES and memory is still busy
//   stall         : this cycle is a wait cycle
// TIMEOUT_CYCLES = 0 disables the timeout.
// ---------------------------------------------------------------------------
module ctrl_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic mem_ready,
    input  logic state_change,
    output logic timeout,
    output logic stall
);

    logic [CNT_W-1:0] cnt_reg;

    assign stall = waiting & ~mem_ready;

    // The counter holds the number of wait cycles already spent in the
    // current state, so the compare fires on the cycle after the last
    // permitted wait; a mem_ready in that cycle still wins.
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign timeout = 1'b0;
        end else begin : g_timeout
            assign timeout = stall && (cnt_reg == CNT_W'(TIMEOUT_CYCLES));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || state_change) begin
            cnt_reg <= '0;
        end else if (stall) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/main_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// main_ctrl_fsm
// Multi-cycle main control unit of the 16-bit CPU. Sequences each
// instruction through fetch / decode / execute / memory / writeback and
// drives datapath enables, mux selects and ALUOp.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   opcode[3:0]              IR[15:12], valid from DECODE
//   zero                     ALU zero flag (branch decision)
//   mem_ready                memory finished the current request
//   alu_op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
//   mem_read, mem_write, reg_write, reg_dst, mem_to_reg
//                            datapath controls
//   illegal_op               one-cycle pulse on an undefined opcode
//   bus_err                  sticky, set on memory timeout
//   halted                   high in HALT
//   state_o[3:0]             current state code (debug)
//
// Optional feature macro CTRL_PERF_EN adds retired_cnt[15:0] (wrapping
// retired-instruction count) and stall_cnt[15:0] (saturating wait count).
//
// Moore outputs are registered from the next state, so they change in the
// same cycle as the state register. ir_write / pc_write in FETCH, pc_write
// in BRANCH and illegal_op are combinational on the current inputs.
// ---------------------------------------------------------------------------
module main_ctrl_fsm
    import cpu16_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic       bus_err,
    output logic       halted,
    output logic [3:0] state_o
`ifdef CTRL_PERF_EN
    ,
    output logic [15:0] retired_cnt,
    output logic [15:0] stall_cnt
`endif
);

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] op_q_reg;
    logic [3:0] op_eff;
    ctrl_t      ctrl_reg;
    ctrl_t      ctrl_next;
    logic       bus_err_reg;

    logic       waiting;
    logic       timeout;
    logic       stall;
    logic       state_change;
    logic       branch_cond;
    logic       fetch_done;

    // ------------------------------------------------------------------
    // Wait counter / timeout
    // ------------------------------------------------------------------
    assign waiting = (state_reg == FETCH_S) || (state_reg == MEMRD_S) ||
                     (state_reg == MEMWR_S);
    assign state_change = (state_next != state_reg);

    ctrl_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_wait_timer (
        .clk          (clk),
        .rst          (rst),
        .waiting      (waiting),
        .mem_ready    (mem_ready),
        .state_change (state_change),
        .timeout      (timeout),
        .stall        (stall)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RST_S:    state_next = FETCH_S;
            FETCH_S: begin
                if (mem_ready)    state_next = DECODE_S;
                else if (timeout) state_next = HALT_S;
            end
            DECODE_S: begin
                case (opcode)
                    OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI: state_next = EXEC_S;
                    OP_LW, OP_SW:                       state_next = MEMADR_S;
                    OP_BEQ, OP_BNE:                     state_next = BRANCH_S;
                    OP_JMP:                             state_next = JUMP_S;
                    OP_HALT:                            state_next = HALT_S;
                    default:                            state_next = FETCH_S;
                endcase
            end
            EXEC_S:   state_next = ALUWB_S;
            ALUWB_S:  state_next = FETCH_S;
            MEMADR_S: state_next = (op_q_reg == OP_SW) ? MEMWR_S : MEMRD_S;
            MEMRD_S: begin
                if (mem_ready)    state_next = MEMWB_S;
                else if (timeout) state_next = HALT_S;
            end
            MEMWB_S:  state_next = FETCH_S;
            MEMWR_S: begin
                if (mem_ready)    state_next = FETCH_S;
                else if (timeout) state_next = HALT_S;
            end
            BRANCH_S: state_next = FETCH_S;
            JUMP_S:   state_next = FETCH_S;
            HALT_S:   state_next = HALT_S;
            default:  state_next = RST_S;
        endcase
        if (rst) state_next = RST_S;
    end

    // The opcode that will be latched when leaving DECODE is the live input;
    // afterwards the latched copy is authoritative.
    assign op_eff    = (state_reg == DECODE_S) ? opcode : op_q_reg;
    assign ctrl_next = moore_ctrl(state_next, op_eff);

    // ------------------------------------------------------------------
    // State, latched opcode, registered Moore outputs, sticky bus error
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= RST_S;
            ctrl_reg    <= '0;
            op_q_reg    <= '0;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= ctrl_next;
            if (state_reg == DECODE_S) op_q_reg <= opcode;
            if (timeout) bus_err_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fetch_done  = (state_reg == FETCH_S) && mem_ready;
    assign branch_cond = (op_q_reg == OP_BNE) ? ~zero : zero;

    assign alu_op     = ctrl_reg.alu_op;
    assign alu_src_a  = ctrl_reg.alu_src_a;
    assign alu_src_b  = ctrl_reg.alu_src_b;
    assign pc_src     = ctrl_reg.pc_src;
    assign mem_read   = ctrl_reg.mem_read;
    assign mem_write  = ctrl_reg.mem_write;
    assign reg_write  = ctrl_reg.reg_write;
    assign reg_dst    = ctrl_reg.reg_dst;
    assign mem_to_reg = ctrl_reg.mem_to_reg;
    assign halted     = ctrl_reg.halted;
    assign bus_err    = bus_err_reg;
    assign state_o    = state_reg;

    assign ir_write   = fetch_done;
    assign pc_write   = ctrl_reg.pc_write | fetch_done |
                        ((state_reg == BRANCH_S) & branch_cond);
    assign illegal_op = (state_reg == DECODE_S) && !op_is_legal(opcode);

`ifdef CTRL_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [15:0] retired_reg;
    logic [15:0] stall_reg;
    logic        retire;

    // An instruction retires when the FSM returns to FETCH from a final
    // state; illegal opcodes (DECODE -> FETCH) do not count.
    assign retire = (state_next == FETCH_S) &&
                    (state_reg inside {ALUWB_S, MEMWB_S, MEMWR_S, BRANCH_S, JUMP_S});

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_reg <= '0;
            stall_reg   <= '0;
        end else begin
            if (retire) retired_reg <= retired_reg + 16'd1;
            if (stall && (stall_reg != 16'hFFFF)) stall_reg <= stall_reg + 16'd1;
        end
    end

    assign retired_cnt = retired_reg;
    assign stall_cnt   = stall_reg;
`endif

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_main_ctrl_fsm
// Randomized instruction stream with a per-instruction reference model of
// the control sequence. Each driven cycle pushes its expected control word
// into a scoreboard queue; a monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_main_ctrl_fsm;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
    logic       bus_err;
    logic       halted;
    logic [3:0] state_o;
`ifdef CTRL_PERF_EN
    logic [15:0] retired_cnt;
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    main_ctrl_fsm #(
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal_op (illegal_op),
        .bus_err    (bus_err),
        .halted     (halted),
        .state_o    (state_o)
`ifdef CTRL_PERF_EN
        ,
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    // Phase tags used in messages
    localparam int T_RST = 0, T_FETCH = 1, T_DECODE = 2, T_EXEC = 3, T_ALUWB = 4,
                   T_MEMADR = 5, T_MEMRD = 6, T_MEMWB = 7, T_MEMWR = 8,
                   T_BRANCH = 9, T_JUMP = 10, T_HALT = 11;

    typedef struct {
        logic [16:0] exp;
        bit          chk;
        bit          st0;
        int          tag;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    bit   model_bus_err = 0;

    logic [16:0] act;
    assign act = {alu_op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write, mem_read,
                  mem_write, reg_write, reg_dst, mem_to_reg, illegal_op, bus_err, halted};

    function automatic string tag_name(input int t);
        case (t)
            T_RST:    return "reset";
            T_FETCH:  return "fetch";
            T_DECODE: return "decode";
            T_EXEC:   return "exec";
            T_ALUWB:  return "aluwb";
            T_MEMADR: return "memadr";
            T_MEMRD:  return "memrd";
            T_MEMWB:  return "memwb";
            T_MEMWR:  return "memwr";
            T_BRANCH: return "branch";
            T_JUMP:   return "jump";
            default:  return "halt";
        endcase
    endfunction

    // Control word: aop, src_a, src_b, pc_write, pc_src, ir_write, mem_read,
    // mem_write, reg_write, reg_dst, mem_to_reg, illegal_op, bus_err, halted
    function automatic logic [16:0] pk(input logic [1:0] aop, input logic sa,
                                       input logic [1:0] sb, input logic pw,
                                       input logic [1:0] ps, input logic irw,
                                       input logic mrd, input logic mwr, input logic rw,
                                       input logic rd, input logic m2r, input logic ill,
                                       input logic be, input logic h);
        return {aop, sa, sb, pw, ps, irw, mrd, mwr, rw, rd, m2r, ill, be, h};
    endfunction

    function automatic logic [16:0] wait_vec(input int tag, input logic mr);
        if (tag == T_FETCH) return pk(2'b00, 0, 2'b01, mr, 2'b00, mr, 1, 0, 0, 0, 0, 0, 0, 0);
        if (tag == T_MEMRD) return pk(2'b00, 0, 2'b00, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        return pk(2'b00, 0, 2'b00, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic cyc(input logic [16:0] e, input bit chk, input bit st0, input int tag,
                       input logic mr, input logic z, input logic [3:0] op);
        exp_t x;
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        x.exp = e;
        x.chk = chk;
        x.st0 = st0;
        x.tag = tag;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // First rst cycle still shows the old state (unchecked); then RST_S
    // with rst high, then RST_S with rst low. mem_ready=1 in the first
    // cycle checks that rst beats a pending fetch completion.
    task automatic do_reset();
        rst = 1'b1;
        cyc(17'd0, 0, 0, T_RST, 1'b1, rb(), rop());
        cyc(17'd0, 1, 0, T_RST, rb(), rb(), rop());
        rst = 1'b0;
        cyc(17'd0, 1, 1, T_RST, rb(), rb(), rop());
        model_bus_err = 0;
    endtask

    task automatic do_halt(input int n);
        for (int i = 0; i < n; i++)
            cyc(pk(2'b00, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, model_bus_err, 1),
                1, 0, T_HALT, rb(), rb(), rop());
        do_reset();
    endtask

    // w wait cycles; then either mem_ready, or (tmo) one more idle cycle
    // that trips the timeout.
    task automatic wait_phase(input int tag, input int w, input bit tmo, output bit timed_out);
        for (int k = 0; k < w; k++) cyc(wait_vec(tag, 1'b0), 1, 0, tag, 1'b0, rb(), rop());
        if (tmo) begin
            cyc(wait_vec(tag, 1'b0), 1, 0, tag, 1'b0, rb(), rop());
            timed_out = 1;
        end else begin
            cyc(wait_vec(tag, 1'b1), 1, 0, tag, 1'b1, rb(), rop());
            timed_out = 0;
        end
    endtask

    task automatic do_instr(input logic [3:0] op, input int wf, input bit tf,
                            input int wm, input bit tm, input int z);
        bit   to;
        bit   ill;
        logic isr;
        logic zz;
        logic take;
        $display("instr op=%h fetch_waits=%0d tmo=%0d mem_waits=%0d tmo=%0d",
                 op, wf, tf, wm, tm);
        wait_phase(T_FETCH, wf, tf, to);
        if (to) begin
            model_bus_err = 1;
            do_halt(3);
            return;
        end
        ill = !((op <= 4'h8) || (op == 4'hF));
        cyc(pk(2'b00, 0, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0, 0, ill, 0, 0), 1, 0, T_DECODE,
            rb(), rb(), op);
        if (ill) return;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3: begin
                isr = (op == 4'h0);
                if (isr) cyc(pk(2'b10, 1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                             1, 0, T_EXEC, rb(), rb(), rop());
                else     cyc(pk(2'b11, 1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                             1, 0, T_EXEC, rb(), rb(), rop());
                cyc(pk(2'b00, 0, 2'b00, 0, 2'b00, 0, 0, 0, 1, isr, 0, 0, 0, 0),
                    1, 0, T_ALUWB, rb(), rb(), rop());
            end
            4'h4, 4'h5: begin
                cyc(pk(2'b00, 1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                    1, 0, T_MEMADR, rb(), rb(), rop());
                wait_phase((op == 4'h4) ? T_MEMRD : T_MEMWR, wm, tm, to);
                if (to) begin
                    model_bus_err = 1;
                    do_halt(3);
                end else if (op == 4'h4) begin
                    cyc(pk(2'b00, 0, 2'b00, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0, 0),
                        1, 0, T_MEMWB, rb(), rb(), rop());
                end
            end
            4'h6, 4'h7: begin
                zz   = (z < 0) ? rb() : 1'(z);
                take = (op == 4'h6) ? zz : ~zz;
                cyc(pk(2'b01, 1, 2'b00, take, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                    1, 0, T_BRANCH, rb(), zz, rop());
            end
            4'h8: cyc(pk(2'b00, 0, 2'b00, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                      1, 0, T_JUMP, rb(), rb(), rop());
            default: do_halt(3);
        endcase
    endtask

    // Monitor / scoreboard checker
    initial begin
        forever begin
            exp_t x;
            @(negedge clk);
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                if (x.chk) begin
                    total++;
                    if (act !== x.exp) begin
                        bad++;
                        $display("FAIL %s: got %b want %b", tag_name(x.tag), act, x.exp);
                    end
                end
                if (x.st0) begin
                    total++;
                    if (state_o !== 4'd0) begin
                        bad++;
                        $display("FAIL state_rst: got %0d want 0", state_o);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wf, wm;
        bit tf, tm;
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        // Directed cases
        do_instr(4'h0, 0, 0, 0, 0, -1);   // R-type, no waits
        do_instr(4'h1, 2, 0, 0, 0, -1);   // ADDI with fetch waits
        do_instr(4'h4, 0, 0, 3, 0, -1);   // LW, 3 waits in MEMRD
        do_instr(4'h5, 0, 0, 1, 0, -1);   // SW
        do_instr(4'h6, 0, 0, 0, 0, 1);    // BEQ taken
        do_instr(4'h6, 0, 0, 0, 0, 0);    // BEQ not taken
        do_instr(4'h7, 0, 0, 0, 0, 1);    // BNE not taken
        do_instr(4'h7, 0, 0, 0, 0, 0);    // BNE taken
        do_instr(4'h8, 1, 0, 0, 0, -1);   // JMP
        do_instr(4'hA, 0, 0, 0, 0, -1);   // illegal
        do_instr(4'h0, TMO, 0, 0, 0, -1); // mem_ready on the timeout cycle wins
        do_instr(4'h0, TMO, 1, 0, 0, -1); // fetch timeout
        do_instr(4'h4, 0, 0, TMO, 1, -1); // MEMRD timeout
        do_instr(4'h5, 0, 0, TMO, 1, -1); // MEMWR timeout
        do_instr(4'hF, 0, 0, 0, 0, -1);   // HALT
        // Random stream
        for (int i = 0; i < 400; i++) begin
            wf = $urandom_range(0, TMO);
            wm = $urandom_range(0, TMO);
            tf = (wf == TMO) && ($urandom_range(0, 3) == 0);
            tm = (wm == TMO) && ($urandom_range(0, 3) == 0);
            do_instr(rop(), wf, tf, wm, tm, -1);
            if ($urandom_range(0, 29) == 0) do_reset();
        end
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
